// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcode map, phase encoding and
// the table of T-states that need a memory access.
package cpu_ctrl_pkg;

    localparam int NUM_INSTR = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_MVAC = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_JUMP = 4'h5;
    localparam logic [3:0] OP_JMPZ = 4'h6;
    localparam logic [3:0] OP_JPNZ = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_INAC = 4'hA;
    localparam logic [3:0] OP_CLAC = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    typedef enum logic [1:0] {
        EXEC = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } phase_e;

    function automatic logic is_mem_state(input logic [3:0] opcode, input logic [2:0] tcount);
        logic mem;
        mem = 1'b0;
        case (tcount)
            3'd1:       mem = 1'b1;
            3'd3, 3'd4: mem = (opcode == OP_LDAC) || (opcode == OP_STAC) || (opcode == OP_JUMP) ||
                              (opcode == OP_JMPZ) || (opcode == OP_JPNZ);
            3'd6:       mem = (opcode == OP_LDAC);
            3'd7:       mem = (opcode == OP_STAC);
            default:    mem = 1'b0;
        endcase
        return mem;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Pure 4-to-16 one-hot instruction decode.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]           op_i,
    output logic [NUM_INSTR-1:0] dec_o
);

    always_comb begin
        dec_o       = '0;
        dec_o[op_i] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Timing/decode sequencer: one-hot T-states with memory wait insertion,
// single-step halting, opcode latch/decode, zero flag and sticky error flags.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                CLK,
    input  logic                CLEAR,
    input  logic                SOFT_RESET,
    input  logic                IR_LOAD,
    input  logic [OPCODE_W-1:0] IR_IN,
    input  logic                Z_IN,
    input  logic                Z_LOAD,
    input  logic                MEM_READY,
    input  logic                STEP_MODE,
    input  logic                STEP,
    output logic                T0, T1, T2, T3, T4, T5, T6, T7,
    output logic                INOP, ILDAC, ISTAC, IMVAC, IMOVR, IJUMP, IJMPZ, IJPNZ,
    output logic                IADD, ISUB, IINAC, ICLAC, IAND, IOR, IXOR, INOT,
    output logic                Z,
    output logic                MEM_REQ,
    output logic                HALTED,
    output logic                SEQ_ERR,
    output logic                MEM_TMO
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    phase_e              phase_q, phase_d;
    logic [2:0]          tcount_q, tcount_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [7:0]          wait_q, wait_d;
    logic                z_q, z_d;
    logic                seq_err_q, seq_err_d;
    logic                mem_tmo_q, mem_tmo_d;
    logic                step_prev_q;
    logic                step_edge;
    logic [7:0]          t_lines;
    logic [NUM_INSTR-1:0] dec;

    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            phase_q     <= EXEC;
            tcount_q    <= '0;
            opcode_q    <= '0;
            wait_q      <= '0;
            z_q         <= 1'b0;
            seq_err_q   <= 1'b0;
            mem_tmo_q   <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            tcount_q    <= tcount_d;
            opcode_q    <= opcode_d;
            wait_q      <= wait_d;
            z_q         <= z_d;
            seq_err_q   <= seq_err_d;
            mem_tmo_q   <= mem_tmo_d;
            step_prev_q <= STEP;
        end
    end

    assign step_edge = STEP & ~step_prev_q;

    always_comb begin
        phase_d   = phase_q;
        tcount_d  = tcount_q;
        wait_d    = wait_q;
        seq_err_d = seq_err_q;
        mem_tmo_d = mem_tmo_q;
        opcode_d  = IR_LOAD ? IR_IN : opcode_q;
        z_d       = Z_LOAD ? Z_IN : z_q;
        unique case (phase_q)
            EXEC: begin
                if (SOFT_RESET) begin
                    tcount_d = '0;
                    phase_d  = STEP_MODE ? HALT : EXEC;
                end else if (tcount_q == 3'd7) begin
                    tcount_d  = '0;
                    seq_err_d = 1'b1;
                end else begin
                    tcount_d = tcount_q + 3'd1;
                    // An opcode loaded on this same edge already governs the next state.
                    if (is_mem_state(4'(opcode_d), tcount_d)) begin
                        phase_d = WAIT;
                        wait_d  = '0;
                    end
                end
            end
            WAIT: begin
                if (MEM_READY) begin
                    phase_d = EXEC;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    mem_tmo_d = 1'b1;
                    tcount_d  = '0;
                    phase_d   = EXEC;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            HALT: begin
                if (step_edge || !STEP_MODE) begin
                    phase_d = EXEC;
                end
            end
            default: begin
                phase_d  = EXEC;
                tcount_d = '0;
            end
        endcase
    end

    // T lines are forced low combinationally while CLEAR is held.
    assign t_lines = (phase_q == EXEC && !CLEAR) ? (8'b1 << tcount_q) : '0;
    assign {T7, T6, T5, T4, T3, T2, T1, T0} = t_lines;

    opcode_decoder u_decoder (
        .op_i  (4'(opcode_q)),
        .dec_o (dec)
    );

    assign {INOT, IXOR, IOR, IAND, ICLAC, IINAC, ISUB, IADD,
            IJPNZ, IJMPZ, IJUMP, IMOVR, IMVAC, ISTAC, ILDAC, INOP} = dec;

    assign Z       = z_q;
    assign MEM_REQ = (phase_q == WAIT);
    assign HALTED  = (phase_q == HALT);
    assign SEQ_ERR = seq_err_q;
    assign MEM_TMO = mem_tmo_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios with literal
// T-state traces, then randomized stimulus against a behavioural model.
module tb_control_sequencer;

    localparam int WAIT_LIMIT = 15;

    logic CLK;
    logic CLEAR, SOFT_RESET, IR_LOAD, Z_IN, Z_LOAD, MEM_READY, STEP_MODE, STEP;
    logic [3:0] IR_IN;
    logic T0, T1, T2, T3, T4, T5, T6, T7;
    logic INOP, ILDAC, ISTAC, IMVAC, IMOVR, IJUMP, IJMPZ, IJPNZ;
    logic IADD, ISUB, IINAC, ICLAC, IAND, IOR, IXOR, INOT;
    logic Z, MEM_REQ, HALTED, SEQ_ERR, MEM_TMO;

    control_sequencer #(.OPCODE_W(4), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .CLK(CLK), .CLEAR(CLEAR), .SOFT_RESET(SOFT_RESET), .IR_LOAD(IR_LOAD), .IR_IN(IR_IN),
        .Z_IN(Z_IN), .Z_LOAD(Z_LOAD), .MEM_READY(MEM_READY), .STEP_MODE(STEP_MODE), .STEP(STEP),
        .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7),
        .INOP(INOP), .ILDAC(ILDAC), .ISTAC(ISTAC), .IMVAC(IMVAC), .IMOVR(IMOVR), .IJUMP(IJUMP),
        .IJMPZ(IJMPZ), .IJPNZ(IJPNZ), .IADD(IADD), .ISUB(ISUB), .IINAC(IINAC), .ICLAC(ICLAC),
        .IAND(IAND), .IOR(IOR), .IXOR(IXOR), .INOT(INOT),
        .Z(Z), .MEM_REQ(MEM_REQ), .HALTED(HALTED), .SEQ_ERR(SEQ_ERR), .MEM_TMO(MEM_TMO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Behavioural model: which T-state we are in, whether we are parked on memory or halted.
    typedef enum {M_RUN, M_WAIT, M_HALT} mmode_e;
    mmode_e m_mode;
    int     m_t, m_waits;
    logic [3:0] m_op;
    logic   m_z, m_seqerr, m_tmo, m_stepprev;
    bit     mem_tbl [16][8];
    logic [3:0] nxt_op;
    int     trace_q[$];

    assign nxt_op = IR_LOAD ? IR_IN : m_op;

    initial begin
        for (int o = 0; o < 16; o++) begin
            for (int t = 0; t < 8; t++) mem_tbl[o][t] = 1'b0;
            mem_tbl[o][1] = 1'b1;
        end
        foreach (mem_tbl[o]) begin
            if (o == 1 || o == 2 || o == 5 || o == 6 || o == 7) begin
                mem_tbl[o][3] = 1'b1;
                mem_tbl[o][4] = 1'b1;
            end
        end
        mem_tbl[1][6] = 1'b1;
        mem_tbl[2][7] = 1'b1;
    end

    always @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            m_mode <= M_RUN; m_t <= 0; m_waits <= 0; m_op <= 4'd0;
            m_z <= 1'b0; m_seqerr <= 1'b0; m_tmo <= 1'b0; m_stepprev <= 1'b0;
        end else begin
            m_op <= nxt_op;
            m_stepprev <= STEP;
            if (Z_LOAD) m_z <= Z_IN;
            case (m_mode)
                M_RUN: begin
                    if (SOFT_RESET) begin
                        m_t <= 0;
                        m_mode <= STEP_MODE ? M_HALT : M_RUN;
                    end else if (m_t == 7) begin
                        m_t <= 0;
                        m_seqerr <= 1'b1;
                    end else begin
                        m_t <= m_t + 1;
                        if (mem_tbl[nxt_op][m_t + 1]) begin
                            m_mode <= M_WAIT;
                            m_waits <= 0;
                        end
                    end
                end
                M_WAIT: begin
                    if (MEM_READY) m_mode <= M_RUN;
                    else if (m_waits + 1 == WAIT_LIMIT) begin
                        m_tmo <= 1'b1; m_t <= 0; m_mode <= M_RUN;
                    end else m_waits <= m_waits + 1;
                end
                default: begin
                    if ((STEP && !m_stepprev) || !STEP_MODE) begin
                        m_mode <= M_RUN; m_t <= 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge CLK) begin
        logic [7:0]  exp_t, got_t;
        logic [15:0] exp_d, got_d;
        logic [4:0]  exp_s, got_s;
        exp_t = (!CLEAR && m_mode == M_RUN) ? (8'd1 << m_t) : 8'd0;
        got_t = {T7, T6, T5, T4, T3, T2, T1, T0};
        exp_d = 16'd1 << m_op;
        got_d = {INOT, IXOR, IOR, IAND, ICLAC, IINAC, ISUB, IADD,
                 IJPNZ, IJMPZ, IJUMP, IMOVR, IMVAC, ISTAC, ILDAC, INOP};
        exp_s = {m_z, m_mode == M_WAIT, m_mode == M_HALT, m_seqerr, m_tmo};
        got_s = {Z, MEM_REQ, HALTED, SEQ_ERR, MEM_TMO};
        checks += 3;
        if (got_t !== exp_t) begin
            failures++;
            $display("FAIL tlines t=%0t got=%b exp=%b", $time, got_t, exp_t);
        end
        if (got_d !== exp_d) begin
            failures++;
            $display("FAIL decode t=%0t got=%b exp=%b", $time, got_d, exp_d);
        end
        if (got_s !== exp_s) begin
            failures++;
            $display("FAIL status(Z,REQ,HALT,SEQ,TMO) t=%0t got=%b exp=%b", $time, got_s, exp_s);
        end
        trace_q.push_back(m_mode == M_RUN ? m_t : (m_mode == M_WAIT ? 8 : 9));
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_trace(input string name, input int exp[$]);
        int bad;
        bad = -1;
        for (int i = 0; i < exp.size() && i < trace_q.size(); i++)
            if (bad < 0 && trace_q[i] != exp[i]) bad = i;
        if (bad < 0 && trace_q.size() != exp.size()) bad = (trace_q.size() < exp.size()) ? trace_q.size() : exp.size();
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL trace_%s idx=%0d got=%0d exp=%0d len_got=%0d len_exp=%0d", name, bad,
                     (bad < trace_q.size()) ? trace_q[bad] : -1, (bad < exp.size()) ? exp[bad] : -1,
                     trace_q.size(), exp.size());
        end
        trace_q.delete();
    endtask

    // Directed-scenario knobs: 8 as soft_at means never issue SOFT_RESET.
    logic [3:0] g_op;
    int g_delay, g_soft_at;
    logic g_step_mode, g_step, g_zload, g_zin;

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            IR_LOAD    = (m_mode == M_RUN && m_t == 1);
            IR_IN      = g_op;
            SOFT_RESET = (m_mode == M_RUN && m_t == g_soft_at);
            MEM_READY  = (m_mode == M_WAIT && m_waits >= g_delay);
            STEP_MODE  = g_step_mode;
            STEP       = g_step;
            Z_LOAD     = g_zload;
            Z_IN       = g_zin;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea[$];
        logic rdy_rare;
        CLEAR = 1'b1; SOFT_RESET = 0; IR_LOAD = 0; IR_IN = 0; Z_IN = 0; Z_LOAD = 0;
        MEM_READY = 0; STEP_MODE = 0; STEP = 0;
        g_op = 0; g_delay = 0; g_soft_at = 8; g_step_mode = 0; g_step = 0; g_zload = 0; g_zin = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_lit("rst_T0", 32'(T0), 0);
        check_lit("rst_INOP", 32'(INOP), 1);
        check_lit("rst_flags", 32'({MEM_REQ, HALTED, SEQ_ERR, MEM_TMO, Z}), 0);
        CLEAR = 1'b0;
        #1;
        check_lit("first_T0", 32'(T0), 1);
        trace_q.delete();

        // ADD with memory always ready
        g_op = 4'h8; g_soft_at = 3; g_delay = 0;
        run(4);
        check_lit("add_T3", 32'(T3), 1);
        check_lit("add_IADD", 32'(IADD), 1);
        run(1);
        ea = '{0, 8, 1, 2, 3};
        check_trace("add", ea);

        // LDAC with 3-cycle memory delay
        g_op = 4'h1; g_soft_at = 7; g_delay = 3;
        run(24);
        ea = '{0, 8, 8, 8, 8, 1, 2, 8, 8, 8, 8, 3, 8, 8, 8, 8, 4, 5, 8, 8, 8, 8, 6, 7};
        check_trace("ldac", ea);

        // Single-step NOP
        g_op = 4'h0; g_soft_at = 4; g_delay = 0; g_step_mode = 1; g_step = 0;
        run(9);
        check_lit("step_HALTED", 32'(HALTED), 1);
        g_step = 1;
        run(1);
        run(9);
        g_step_mode = 0;
        run(1);
        g_step = 0;
        ea = '{0, 8, 1, 2, 3, 4, 9, 9, 9, 9, 0, 8, 1, 2, 3, 4, 9, 9, 9, 9};
        check_trace("step", ea);

        // Missing SOFT_RESET wraps and sets SEQ_ERR
        g_soft_at = 8;
        run(10);
        g_soft_at = 2;
        run(3);
        check_lit("seq_err", 32'(SEQ_ERR), 1);
        ea = '{0, 8, 1, 2, 3, 4, 5, 6, 7, 0, 8, 1, 2};
        check_trace("wrap", ea);

        // Memory never ready: timeout after WAIT_LIMIT cycles
        g_delay = 1000;
        run(16);
        check_lit("tmo_flag", 32'(MEM_TMO), 1);
        check_lit("tmo_T0", 32'(T0), 1);
        ea = '{0, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
        check_trace("tmo", ea);

        // CLEAR in the middle of STAC at T5
        g_op = 4'h2; g_delay = 0; g_soft_at = 8; g_zload = 1; g_zin = 1;
        run(1);
        g_zload = 0;
        run(7);
        check_lit("stac_T5", 32'(T5), 1);
        check_lit("stac_Z", 32'(Z), 1);
        check_lit("stac_ISTAC", 32'(ISTAC), 1);
        CLEAR = 1'b1;
        #1;
        check_lit("clr_tlines", 32'({T7, T6, T5, T4, T3, T2, T1, T0}), 0);
        check_lit("clr_INOP", 32'(INOP), 1);
        check_lit("clr_flags", 32'({Z, SEQ_ERR, MEM_TMO, MEM_REQ, HALTED}), 0);
        @(posedge CLK); #1;
        CLEAR = 1'b0;
        #1;
        check_lit("restart_T0", 32'(T0), 1);

        // Randomized traffic
        rdy_rare = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) rdy_rare = ($urandom_range(0, 2) == 0);
            CLEAR      = ($urandom_range(0, 299) == 0);
            IR_IN      = 4'($urandom);
            IR_LOAD    = ($urandom_range(0, 3) == 0) &&
                         !(m_mode == M_RUN && (m_t == 2 || m_t == 3 || m_t == 5 || m_t == 6));
            SOFT_RESET = (m_mode == M_RUN && m_t >= 2 && $urandom_range(0, 3) == 0) ||
                         ($urandom_range(0, 19) == 0);
            MEM_READY  = rdy_rare ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 49) == 0) STEP_MODE = ~STEP_MODE;
            STEP       = ($urandom_range(0, 3) == 0);
            Z_LOAD     = $urandom_range(0, 1) == 1;
            Z_IN       = $urandom_range(0, 1) == 1;
            @(posedge CLK); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
